// File: rtl/gemm_tile_sequencer.sv
// GEMM tile sequencer: clears the PE array, feeds skewed lane enables
// to both skew banks, waits out array latency, then reads result rows.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-high (1 = reset)
//   start        run one tile (sampled only while idle)
//   data_valid   upstream A/B words present this cycle
//   data_req     sequencer still needs upstream words
//   in_valid_A   per-lane shift enable, ifm skew bank
//   in_valid_B   per-lane shift enable, weight skew bank
//   acc_clear    one-cycle PE accumulator clear
//   out_valid    result row out_row is presented
//   out_ready    consumer accepts the row
//   out_row      index of the presented result row
//   busy         high whenever not idle
//   done         one-cycle pulse at tile completion
module gemm_tile_sequencer #(
  parameter int ARRAY_SIZE   = 16,
  parameter int K_SIZE       = 27,
  parameter int FLUSH_CYCLES = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          data_valid,
  output logic                          data_req,
  output logic [ARRAY_SIZE-1:0]         in_valid_A,
  output logic [ARRAY_SIZE-1:0]         in_valid_B,
  output logic                          acc_clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ARRAY_SIZE)-1:0] out_row,
  output logic                          busy,
  output logic                          done
);

  localparam int TW = $clog2(K_SIZE + ARRAY_SIZE);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int RW = $clog2(ARRAY_SIZE);

  localparam logic [TW-1:0] T_K    = TW'(K_SIZE);
  localparam logic [TW-1:0] T_LAST =
    TW'(K_SIZE + ARRAY_SIZE - 2);
  localparam logic [FW-1:0] F_LAST =
    FW'(FLUSH_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST =
    RW'(ARRAY_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] t;
  logic [TW-1:0] t_n;
  logic [FW-1:0] flush_cnt;
  logic [FW-1:0] flush_n;
  logic [RW-1:0] row_n;
  logic          advance;
  logic [ARRAY_SIZE-1:0] lane;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      t         <= '0;
      flush_cnt <= '0;
      out_row   <= '0;
    end else begin
      state     <= state_n;
      t         <= t_n;
      flush_cnt <= flush_n;
      out_row   <= row_n;
    end
  end

  always_comb begin
    state_n   = state;
    t_n       = t;
    flush_n   = flush_cnt;
    row_n     = out_row;
    advance   = 1'b0;
    data_req  = 1'b0;
    acc_clear = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_n = CLEAR;
      end
      CLEAR: begin
        acc_clear = 1'b1;
        t_n       = '0;
        state_n   = FEED;
      end
      FEED: begin
        data_req = (t < T_K);
        // skew tail drains without upstream data
        advance  = data_req ? data_valid : 1'b1;
        if (advance) begin
          if (t == T_LAST) begin
            t_n     = '0;
            flush_n = '0;
            state_n = FLUSH;
          end else begin
            t_n = t + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == F_LAST) begin
          flush_n = '0;
          row_n   = '0;
          state_n = DRAIN;
        end else begin
          flush_n = flush_cnt + 1'b1;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_row == R_LAST) begin
            row_n   = '0;
            state_n = DONE;
          end else begin
            row_n = out_row + 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // lane i is live for t in [i, i+K_SIZE)
  always_comb begin
    lane = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane[i] = advance
             && (int'(t) >= i)
             && (int'(t) - i < K_SIZE);
    end
    in_valid_A = lane;
    in_valid_B = lane;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
- Sequences one GEMM tile through the systolic datapath: the ifm/weight skew shift registers, the 16x16 PE array and the result readout.
- On start it clears the PE accumulators and issues per-lane skewed in_valid masks to both shift-register banks for K_SIZE words.
- It then waits out the array pipeline latency, streams the result rows out under a valid/ready handshake, and pulses done.

Parameters:
ARRAY_SIZE, 16, number of lanes/rows/columns of the PE array
K_SIZE, 27, reduction depth (words per lane per tile)
FLUSH_CYCLES, 32, idle cycles between the last feed advance and the first readout (covers array propagation)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-high (1 = reset); port name kept for interface uniformity
start  input  1  request to run one tile; sampled only in IDLE
data_valid  input  1  upstream A/B words are present on the shift-register inputs this cycle
data_req  output  1  sequencer still needs upstream words (FEED state and t < K_SIZE)
in_valid_A  output  ARRAY_SIZE  per-lane shift enable, ifm buffer
in_valid_B  output  ARRAY_SIZE  per-lane shift enable, weight buffer
acc_clear  output  1  one-cycle clear of the PE accumulators
out_valid  output  1  result row out_row is presented
out_ready  input  1  consumer accepts the row
out_row  output  $clog2(ARRAY_SIZE)  index of the result row presented
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at tile completion

Behaviour:
- Reset (rst_n=1 at an edge), from any state, mid-tile included: state=IDLE; counters t, flush_cnt and out_row = 0; all outputs 0 on the following cycle. No partial done.
- States: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 moves to CLEAR next cycle. start is ignored in every other state; it is neither queued nor counted.
- CLEAR: exactly one cycle. acc_clear=1, all in_valid=0. Next state FEED with t=0.
- FEED:
  - advance = data_valid when t < K_SIZE, otherwise 1. Skew-tail cycles never wait on upstream.
  - in_valid_A[i] = in_valid_B[i] = advance && (t >= i) && (t - i < K_SIZE). Combinational from t and data_valid.
  - t increments on advance.
  - When t == K_SIZE+ARRAY_SIZE-2 and advance=1, the next state is FLUSH. This gives exactly K_SIZE+ARRAY_SIZE-1 advances, i.e. 42 at defaults.
  - data_req = (t < K_SIZE).
  - Lane i receives exactly K_SIZE pulses; lane 0 pulses on advances 0..K_SIZE-1.
- FLUSH: flush_cnt counts 0..FLUSH_CYCLES-1, then moves to DRAIN. All in_valid=0.
- DRAIN:
  - out_valid=1, out_row as held.
  - On out_valid&&out_ready, out_row increments.
  - On a handshake with out_row == ARRAY_SIZE-1, the next state is DONE and out_row returns to 0.
  - out_ready low holds out_row stable indefinitely.
- DONE: done=1 for one cycle, busy=1, then IDLE. A start in IDLE on the next cycle begins a new tile.
- acc_clear, done and out_valid are never asserted in the same cycle.
- Counter widths: t is $clog2(K_SIZE+ARRAY_SIZE) bits, flush_cnt is $clog2(FLUSH_CYCLES+1) bits. Counters never wrap within a tile.

Test Plan:
- Reset, start=1 one cycle, data_valid=1 constant, out_ready=1 -> acc_clear high cycle 1; in_valid_A[0] high 27 cycles, in_valid_A[15] first high on advance 15 and last on advance 41; 42 FEED cycles, 32 FLUSH, out_row 0..15 over 16 cycles; done pulses once at cycle 92; busy high cycles 1..92.
- data_valid toggled 1,0,1,0 during t<27 -> all in_valid and t freeze on data_valid=0 cycles; each lane still totals exactly 27 pulses; tail t=27..41 proceeds with data_valid=0.
- out_ready held 0 for 5 cycles at out_row=3 -> out_valid stays 1, out_row stays 3, done delayed by exactly 5 cycles.
- start pulsed during FEED, FLUSH and DRAIN -> ignored; exactly one done; back-to-back start the cycle after done -> second tile identical to the first.
- rst_n=1 one cycle at t=20 of FEED -> next cycle state IDLE, all outputs 0, no done; a subsequent start runs a full normal tile.
- Per-lane pulse counter over a random data_valid pattern -> every lane of in_valid_A and in_valid_B counts 27; in_valid_A == in_valid_B on every cycle.
